// File: rtl/spi_fifo_axis_packer.sv
// Packs bytes drained from the SPI read-data FIFO into AXI-Stream beats, lane 0 first,
// and closes each read transaction with a TLAST beat once read_complete has risen and the FIFO has drained.
module spi_fifo_axis_packer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned EMPTY_SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    fifo_not_empty,
    input  logic [7:0]              fifo_dout,
    output logic                    fifo_rd_en,
    input  logic                    read_complete,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [15:0]             beat_count,
    output logic                    busy
);

    localparam int unsigned BPW = DATA_WIDTH / 8;
    localparam int unsigned CW  = $clog2(BPW + 1);
    localparam int unsigned ECW = (EMPTY_SETTLE < 1) ? 1 : $clog2(EMPTY_SETTLE + 1);

    typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   acc;
    logic                    pending_last;
    logic [ECW-1:0]          empty_cnt;
    logic                    rc_q;

    logic                    rc_rise;
    logic                    flush;
    logic                    cnt_full;
    logic                    handshake;
    logic                    send_go;
    logic                    send_last;
    logic                    drop_pend;
    logic [BPW-1:0]          keep_c;

    assign rc_rise    = read_complete & ~rc_q;
    assign flush      = pending_last && (empty_cnt >= ECW'(EMPTY_SETTLE));
    assign cnt_full   = (cnt == CW'(BPW));
    assign handshake  = m_axis_tvalid && m_axis_tready;
    assign fifo_rd_en = (state == RD);
    assign busy       = (state != IDLE) || (cnt != '0) || pending_last;

    // Contiguous lane mask covering the cnt bytes collected so far
    always_comb begin
        keep_c = '0;
        for (int unsigned i = 0; i < BPW; i++) begin
            keep_c[i] = (CW'(i) < cnt);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // A full word waits in IDLE so that a following byte or flush decides whether it carries TLAST
    always_comb begin
        state_nxt = state;
        send_go   = 1'b0;
        send_last = 1'b0;
        drop_pend = 1'b0;
        case (state)
            IDLE: begin
                if (cnt_full && fifo_not_empty) begin
                    state_nxt = SEND;
                    send_go   = 1'b1;
                end else if (cnt_full && flush) begin
                    state_nxt = SEND;
                    send_go   = 1'b1;
                    send_last = 1'b1;
                end else if (!cnt_full && fifo_not_empty) begin
                    state_nxt = RD;
                end else if ((cnt != '0) && flush) begin
                    state_nxt = SEND;
                    send_go   = 1'b1;
                    send_last = 1'b1;
                end else if (flush) begin
                    drop_pend = 1'b1;
                end
            end
            RD:      state_nxt = CAP;
            CAP:     state_nxt = IDLE;
            SEND:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt           <= '0;
            acc           <= '0;
            pending_last  <= 1'b0;
            empty_cnt     <= '0;
            rc_q          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            beat_count    <= '0;
        end else begin
            rc_q <= read_complete;

            if (fifo_not_empty)                      empty_cnt <= '0;
            else if (empty_cnt < ECW'(EMPTY_SETTLE)) empty_cnt <= empty_cnt + ECW'(1);

            // A new edge outranks a simultaneous clear so it is never lost
            if (rc_rise)                                        pending_last <= 1'b1;
            else if ((handshake && m_axis_tlast) || drop_pend)  pending_last <= 1'b0;

            if (state == CAP) begin
                for (int unsigned i = 0; i < BPW; i++) begin
                    if (cnt == CW'(i)) acc[8*i +: 8] <= fifo_dout;
                end
                cnt <= cnt + CW'(1);
            end

            if (state == IDLE && send_go) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= acc;
                m_axis_tkeep  <= keep_c;
                m_axis_tlast  <= send_last;
            end else if (state == SEND && handshake) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tkeep  <= '0;
                m_axis_tlast  <= 1'b0;
                cnt           <= '0;
                acc           <= '0;
                beat_count    <= beat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_fifo_axis_packer.sv
// Directed bench for spi_fifo_axis_packer: a behavioural byte FIFO feeds the DUT, a monitor
// records handshaked beats, and every result is compared against hand-computed values.
module tb_spi_fifo_axis_packer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fifo_not_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        read_complete;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] beat_count;
    logic        busy;

    logic        push_en;
    logic [7:0]  push_data;
    logic [7:0]  fifo_q[$];
    int          underflow = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;
    beat_t beats[$];

    int n_cmp = 0;
    int n_err = 0;

    spi_fifo_axis_packer #(.DATA_WIDTH(32), .EMPTY_SETTLE(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .fifo_not_empty(fifo_not_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .read_complete (read_complete),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .beat_count    (beat_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Standard-mode FIFO: data appears the cycle after the read strobe
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_q.delete();
            fifo_not_empty <= 1'b0;
            fifo_dout      <= 8'h00;
        end else begin
            if (fifo_rd_en) begin
                if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
                else                    underflow++;
            end
            if (push_en) fifo_q.push_back(push_data);
            fifo_not_empty <= (fifo_q.size() != 0);
        end
    end

    // Beat handshakes happen at the next posedge; inputs are stable from posedge+1 onward
    always @(negedge clk) begin
        if (rstn && m_axis_tvalid && m_axis_tready)
            beats.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        push_en   = 1'b1;
        push_data = b;
        tick();
        push_en   = 1'b0;
    endtask

    task automatic pulse_rc();
        read_complete = 1'b1;
        tick();
        read_complete = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int c = 0;
        while (beats.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (beats.size() < n) check({tag, "_timeout"}, 64'(beats.size()), 64'(n));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int c = 0;
        while (!m_axis_tvalid && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_beat(input string tag, input int idx,
                              input logic [31:0] d, input logic [3:0] k, input logic l);
        if (idx < beats.size()) begin
            check({tag, "_data"}, 64'(beats[idx].d), 64'(d));
            check({tag, "_keep"}, 64'(beats[idx].k), 64'(k));
            check({tag, "_last"}, 64'(beats[idx].l), 64'(l));
        end else begin
            check({tag, "_missing"}, 64'(beats.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int unstable;
        int rd_seen;

        rstn          = 1'b0;
        read_complete = 1'b0;
        m_axis_tready = 1'b1;
        push_en       = 1'b0;
        push_data     = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata",  64'(m_axis_tdata),  64'd0);
        check("rst_tkeep",  64'(m_axis_tkeep),  64'd0);
        check("rst_tlast",  64'(m_axis_tlast),  64'd0);
        check("rst_rd_en",  64'(fifo_rd_en),    64'd0);
        check("rst_count",  64'(beat_count),    64'd0);
        check("rst_busy",   64'(busy),          64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // 1: eight bytes then read_complete -> two full beats, second carries TLAST
        beats.delete();
        for (int i = 1; i <= 8; i++) push(8'(i));
        pulse_rc();
        wait_beats("t1", 2, 200);
        check_beat("t1_b0", 0, 32'h04030201, 4'hF, 1'b0);
        check_beat("t1_b1", 1, 32'h08070605, 4'hF, 1'b1);
        wait_idle("t1", 50);
        check("t1_count", 64'(beat_count), 64'd2);
        check("t1_nbeats", 64'(beats.size()), 64'd2);

        // 2: five bytes -> full beat then a one-byte TLAST beat
        beats.delete();
        for (int i = 1; i <= 5; i++) push(8'(i));
        pulse_rc();
        wait_beats("t2", 2, 200);
        check_beat("t2_b0", 0, 32'h04030201, 4'hF, 1'b0);
        check_beat("t2_b1", 1, 32'h00000005, 4'h1, 1'b1);
        wait_idle("t2", 50);
        check("t2_count", 64'(beat_count), 64'd4);

        // 3: read_complete with no data -> pending set then dropped, no beat
        beats.delete();
        pulse_rc();
        check("t3_busy_set", 64'(busy), 64'd1);
        tick();
        check("t3_busy_clr", 64'(busy), 64'd0);
        repeat (5) tick();
        check("t3_count", 64'(beat_count), 64'd4);
        check("t3_nbeats", 64'(beats.size()), 64'd0);

        // 4: backpressure holds the beat stable and stops FIFO reads
        beats.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        wait_valid("t4", 100);
        unstable = 0;
        rd_seen  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!m_axis_tvalid || m_axis_tdata !== 32'h14131211 ||
                m_axis_tkeep !== 4'hF || m_axis_tlast !== 1'b0) unstable++;
            if (fifo_rd_en) rd_seen++;
        end
        check("t4_stable", 64'(unstable), 64'd0);
        check("t4_rd_en", 64'(rd_seen), 64'd0);
        check("t4_fifo_held", 64'(fifo_not_empty), 64'd1);
        m_axis_tready = 1'b1;
        pulse_rc();
        wait_beats("t4", 2, 200);
        check_beat("t4_b0", 0, 32'h14131211, 4'hF, 1'b0);
        check_beat("t4_b1", 1, 32'h00000015, 4'h1, 1'b1);
        wait_idle("t4", 50);
        check("t4_count", 64'(beat_count), 64'd6);

        // 5: read_complete rises one cycle before the last byte is visible
        beats.delete();
        push(8'h21);
        push(8'h22);
        repeat (12) tick();
        read_complete = 1'b1;
        push_en       = 1'b1;
        push_data     = 8'h23;
        tick();
        read_complete = 1'b0;
        push_en       = 1'b0;
        wait_beats("t5", 1, 200);
        check_beat("t5_b0", 0, 32'h00232221, 4'h7, 1'b1);
        wait_idle("t5", 50);
        check("t5_nbeats", 64'(beats.size()), 64'd1);
        check("t5_count", 64'(beat_count), 64'd7);

        // 6: reset during SEND drops tvalid at once; a fresh transaction packs correctly
        beats.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
        wait_valid("t6", 100);
        rstn = 1'b0;
        #1;
        check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_rst_count",  64'(beat_count),    64'd0);
        check("t6_rst_busy",   64'(busy),          64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        m_axis_tready = 1'b1;
        beats.delete();
        for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
        pulse_rc();
        wait_beats("t6", 1, 200);
        check_beat("t6_b0", 0, 32'h34333231, 4'hF, 1'b1);
        wait_idle("t6", 50);
        check("t6_count", 64'(beat_count), 64'd1);
        check("t6_nbeats", 64'(beats.size()), 64'd1);

        check("fifo_underflow", 64'(underflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
